// File: rtl/multdiv_pkg.sv
// Shared definitions for the seq_multdiv iterative multiply/divide unit:
// FSM encoding, width defaults and Booth recode opcodes.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam logic [WIDTH_DEF-1:0] INT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        BOOTH_Z   = 3'd0,
        BOOTH_PM  = 3'd1,
        BOOTH_MM  = 3'd2,
        BOOTH_P2M = 3'd3,
        BOOTH_M2M = 3'd4
    } booth_op_t;

    // Radix-4 table; radix-2 reuses it by presenting {q0, q0, q-1}.
    function automatic booth_op_t booth_recode(input logic [2:0] bits);
        booth_op_t op;
        case (bits)
            3'b001, 3'b010: op = BOOTH_PM;
            3'b011:         op = BOOTH_P2M;
            3'b100:         op = BOOTH_M2M;
            3'b101, 3'b110: op = BOOTH_MM;
            default:        op = BOOTH_Z;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for seq_multdiv: sync clear, enable, saturates at the
// terminal value supplied by the caller.
module multdiv_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_val_i,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;

    assign term_o = (cnt_q == term_val_i);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !term_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_multdiv.sv
// Iterative signed multiply (Booth) / divide (non-restoring) unit.
// Define MULTDIV_BOOTH_RADIX4_EN to retire two multiplier bits per iteration.
module seq_multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output state_t           dbg_state_o
);

    // Handshake: a start pulse is accepted in any state and restarts the unit;
    // data_resultRDY is a one-cycle valid with no ready (the consumer always captures).
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int UP_W  = WIDTH + 2;
    localparam int P_W   = 2 * WIDTH + 3;
`ifdef MULTDIV_BOOTH_RADIX4_EN
    localparam int MUL_STEP = 2;
`else
    localparam int MUL_STEP = 1;
`endif
    localparam logic [CNT_W-1:0] MUL_TERM = CNT_W'(WIDTH / MUL_STEP - 1);
    localparam logic [CNT_W-1:0] DIV_TERM = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = INT_MIN[WIDTH_DEF-1 -: WIDTH];

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;

    logic [WIDTH-1:0] mcand_q;
    logic [P_W-1:0]   prod_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic             neg_q;
    logic             dz_q;
    logic             ovf_q;

    logic             start;
    logic             cnt_en;
    logic             cnt_term;
    logic [CNT_W-1:0] term_val;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign cnt_en   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign term_val = (state_q == ST_MUL) ? MUL_TERM : DIV_TERM;

    multdiv_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clock     (clock),
        .reset     (reset),
        .clr_i     (start),
        .en_i      (cnt_en),
        .term_val_i(term_val),
        .term_o    (cnt_term)
    );

    // Booth step; the accumulator carries two guard bits so +/-2M never overflows.
    logic [2:0]         booth_bits;
    logic [UP_W-1:0]    m_ext;
    logic [UP_W-1:0]    m2_ext;
    logic [UP_W-1:0]    addend;
    logic [UP_W-1:0]    upper_sum;
    logic [P_W-1:0]     prod_d;
    logic [2*WIDTH-1:0] product;
    logic               mul_exc;

    always_comb begin
`ifdef MULTDIV_BOOTH_RADIX4_EN
        booth_bits = prod_q[2:0];
`else
        booth_bits = {prod_q[1], prod_q[1:0]};
`endif
        m_ext  = {{2{mcand_q[WIDTH-1]}}, mcand_q};
        m2_ext = {mcand_q[WIDTH-1], mcand_q, 1'b0};
        case (booth_recode(booth_bits))
            BOOTH_PM:  addend = m_ext;
            BOOTH_MM:  addend = -m_ext;
            BOOTH_P2M: addend = m2_ext;
            BOOTH_M2M: addend = -m2_ext;
            default:   addend = '0;
        endcase
        upper_sum = prod_q[P_W-1 -: UP_W] + addend;
        prod_d    = P_W'($signed({upper_sum, prod_q[WIDTH:0]}) >>> MUL_STEP);
        product   = prod_d[2*WIDTH:1];
        mul_exc   = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});
    end

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] div_res;

    always_comb begin
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_d   = rem_q[WIDTH] ? (shifted + {1'b0, dsr_q}) : (shifted - {1'b0, dsr_q});
        quo_d   = {quo_q[WIDTH-2:0], ~rem_d[WIDTH]};
        div_res = dz_q ? '0 : (neg_q ? -quo_d : quo_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand_q <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            mcand_q <= data_operandA;
            prod_q  <= {{UP_W{1'b0}}, data_operandB, 1'b0};
            rem_q   <= '0;
            quo_q   <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
            dsr_q   <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
            neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_q    <= (data_operandB == '0);
            ovf_q   <= (data_operandA == MIN_VAL) && (data_operandB == '1);
        end else if (state_q == ST_MUL) begin
            prod_q <= prod_d;
        end else if (state_q == ST_DIV) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    // The last iteration's combinational result is captured on entry to DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (start) begin
                state_q <= ctrl_MULT ? ST_MUL : ST_DIV;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_MUL: begin
                        if (cnt_term) begin
                            state_q  <= ST_DONE;
                            result_q <= product[WIDTH-1:0];
                            exc_q    <= mul_exc;
                            rdy_q    <= 1'b1;
                        end
                    end
                    ST_DIV: begin
                        if (cnt_term) begin
                            state_q  <= ST_DONE;
                            result_q <= div_res;
                            exc_q    <= dz_q | ovf_q;
                            rdy_q    <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;
    assign dbg_state_o    = state_q;

endmodule
